mld_cyclic_decoder: RTL and testbench

- Parametrised one-step majority-logic decoder for cyclic block codes. It supersedes the fixed (7,4) serial decoder.
- Accepts a serial received word over a valid/ready handshake, then rotates it N times through a circular buffer.
- Each cycle it corrects the bit leaving position N-1 by threshold vote over J parity-check sums, selected per check sum by a parameter mask.
- Presents the corrected word in parallel on a valid/ready output, together with a correction count; sits between the serial channel receiver and the data sink.

---
 rtl/mld_cyclic_decoder.sv | 176 +++++++++++++++++
 tb/tb_mld_cyclic_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mld_cyclic_decoder.sv
// mld_cyclic_decoder: one-step majority-logic decoder for cyclic block codes.
// The received word is shifted in serially and then rotated N times through
// a circular buffer. On each rotation the bit leaving stage N-1 is flipped
// when at least THRESHOLD of the J orthogonal check sums evaluate to 1.
module mld_cyclic_decoder #(
    parameter int N           = 7,
    parameter int J           = 3,
    parameter     CHECK_MASKS = 21'h117158,
    parameter int THRESHOLD   = J / 2 + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_bit,
    input  logic                     correct_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             data_out,
    output logic [$clog2(N+1)-1:0]   err_count,
    output logic                     busy
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int POP_W = $clog2(J + 1);

    localparam logic [J*N-1:0]   MASKS    = CHECK_MASKS;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(N);
    localparam logic [POP_W-1:0] THR      = POP_W'(THRESHOLD);

    // Reject parameter sets the datapath cannot represent.
    if ($bits(CHECK_MASKS) != J * N) begin : g_bad_mask_width
        $error("mld_cyclic_decoder: CHECK_MASKS width must equal J*N");
    end
    if (THRESHOLD < 1 || THRESHOLD > J) begin : g_bad_threshold
        $error("mld_cyclic_decoder: THRESHOLD must lie in 1..J");
    end
    if (N < 3 || N > 64 || J < 1 || J > 16) begin : g_bad_size
        $error("mld_cyclic_decoder: N must be 3..64 and J must be 1..16");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DECODE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Even/odd parity of the selected buffer stages.
    function automatic logic parity_of(input logic [N-1:0] v);
        return ^v;
    endfunction

    // Number of check sums that evaluate to 1.
    function automatic logic [POP_W-1:0] popcount(input logic [J-1:0] v);
        logic [POP_W-1:0] c;
        c = {POP_W{1'b0}};
        for (int k = 0; k < J; k++) begin
            c = c + POP_W'(v[k]);
        end
        return c;
    endfunction

    state_t             state_r,     state_nxt_s;
    logic [N-1:0]       shift_r,     shift_nxt_s;
    logic [CNT_W-1:0]   cnt_r,       cnt_nxt_s;
    logic [CNT_W-1:0]   err_cnt_r,   err_cnt_nxt_s;
    logic               corr_en_r,   corr_en_nxt_s;
    logic               in_ready_r,  in_ready_nxt_s;
    logic               out_valid_r, out_valid_nxt_s;
    logic               busy_r,      busy_nxt_s;
    logic [J-1:0]       chk_s;
    logic               err_s;

    for (genvar j = 0; j < J; j++) begin : g_chk
        assign chk_s[j] = parity_of(shift_r & MASKS[j*N +: N]);
    end

    assign err_s = (popcount(chk_s) >= THR);

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign data_out  = shift_r;
    assign err_count = err_cnt_r;

    // Next-state, datapath update and next handshake flags.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        cnt_nxt_s     = cnt_r;
        err_cnt_nxt_s = err_cnt_r;
        corr_en_nxt_s = corr_en_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s   = ST_LOAD;
                    shift_nxt_s   = {shift_r[N-2:0], in_bit};
                    cnt_nxt_s     = CNT_ONE;
                    err_cnt_nxt_s = CNT_ZERO;
                    corr_en_nxt_s = correct_en;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    shift_nxt_s = {shift_r[N-2:0], in_bit};
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_DECODE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DECODE: begin
                // The decision is counted even when correction is disabled.
                shift_nxt_s = {shift_r[N-2:0], shift_r[N-1] ^ (err_s & corr_en_r)};
                if (err_s && (err_cnt_r != ERR_MAX)) begin
                    err_cnt_nxt_s = err_cnt_r + CNT_ONE;
                end else begin
                    err_cnt_nxt_s = err_cnt_r;
                end
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        in_ready_nxt_s  = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_LOAD);
        out_valid_nxt_s = (state_nxt_s == ST_DONE);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            shift_r     <= {N{1'b0}};
            cnt_r       <= CNT_ZERO;
            err_cnt_r   <= CNT_ZERO;
            corr_en_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            shift_r     <= shift_nxt_s;
            cnt_r       <= cnt_nxt_s;
            err_cnt_r   <= err_cnt_nxt_s;
            corr_en_r   <= corr_en_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_mld_cyclic_decoder.sv
// Testbench for mld_cyclic_decoder: default (7) instance driven from a
// vector table plus handshake/reset sequences, and a (15,7) BCH instance
// fed random double-error codewords.
module tb_mld_cyclic_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid, in_ready, in_bit, correct_en;
    logic       out_valid, out_ready, busy;
    logic [6:0] data_out;
    logic [2:0] err_count;

    logic        v15, rdy15, b15, ce15, ov15, or15, busy15;
    logic [14:0] d15;
    logic [3:0]  c15;

    int errors = 0;
    int checks = 0;

    mld_cyclic_decoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .correct_en(correct_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .err_count(err_count), .busy(busy)
    );

    mld_cyclic_decoder #(
        .N(15), .J(4),
        .CHECK_MASKS({15'h4580, 15'h5808, 15'h6022, 15'h4045})
    ) dut15 (
        .clk(clk), .reset(reset),
        .in_valid(v15), .in_ready(rdy15), .in_bit(b15),
        .correct_en(ce15),
        .out_valid(ov15), .out_ready(or15),
        .data_out(d15), .err_count(c15), .busy(busy15)
    );

    typedef struct {
        logic [6:0] word;
        logic       ce;
        logic [6:0] exp_data;
        logic [2:0] exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, " in_ready"}, in_ready, 1);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " data_out"}, data_out, 0);
        check({tag, " err_count"}, err_count, 0);
    endtask

    task automatic push7(input logic b, input logic ce, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_bit = b; correct_en = ce;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin @(posedge clk); #1; guard++; end
        if (in_ready !== 1'b1) check("push7 in_ready timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send7(input logic [6:0] w, input logic ce, input int maxgap);
        for (int i = 6; i >= 0; i--) begin
            push7(w[i], ce, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic collect7(input string tag, input bit chk_lat, input int hold,
                            output logic [6:0] d, output logic [2:0] c);
        int lat;
        bit bad;
        lat = 0; bad = 1'b0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready !== 1'b0) bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        check({tag, " out_valid seen"}, out_valid, 1);
        if (chk_lat) begin
            check({tag, " latency edges"}, lat, 7);
            check({tag, " in_ready low in decode"}, bad, 0);
        end
        d = data_out; c = err_count;
        bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                data_out !== d || err_count !== c) bad = 1'b1;
            @(posedge clk); #1;
        end
        if (hold > 0) check({tag, " held stable"}, bad, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid dropped"}, out_valid, 0);
    endtask

    function automatic logic [14:0] encode15(input logic [6:0] m);
        logic [14:0] cw;
        logic [14:0] g;
        cw = 15'h0000;
        g  = 15'h01D1;
        for (int k = 0; k < 7; k++) begin
            if (m[k]) cw = cw ^ (g << k);
        end
        return cw;
    endfunction

    task automatic run15(input string tag, input logic [14:0] rx, input logic ce,
                         input logic [14:0] exp_d, input logic [3:0] exp_c);
        int guard;
        for (int i = 14; i >= 0; i--) begin
            v15 = 1'b1; b15 = rx[i]; ce15 = ce;
            guard = 0;
            while (rdy15 !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
            @(posedge clk); #1;
        end
        v15 = 1'b0;
        guard = 0;
        while (ov15 !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        check({tag, " latency edges"}, guard, 15);
        check({tag, " data_out"}, d15, exp_d);
        check({tag, " err_count"}, c15, exp_c);
        or15 = 1'b1;
        @(posedge clk); #1;
        or15 = 1'b0;
    endtask

    vec_t vecs[13];

    initial begin
        logic [6:0]  d, d2;
        logic [2:0]  c, c2;
        logic [6:0]  w;
        logic [14:0] cw, rx;
        int          p1, p2;

        vecs[0]  = '{7'h00, 1'b1, 7'h00, 3'd0};
        for (int p = 0; p < 7; p++) vecs[1 + p] = '{7'h69 ^ (7'h01 << p), 1'b1, 7'h69, 3'd1};
        vecs[8]  = '{7'h6D, 1'b0, 7'h6D, 3'd1};
        vecs[9]  = '{7'h69, 1'b1, 7'h69, 3'd0};
        vecs[10] = '{7'h29, 1'b0, 7'h29, 3'd1};
        vecs[11] = '{7'h73, 1'b1, 7'h53, 3'd1};
        vecs[12] = '{7'h3B, 1'b1, 7'h3A, 3'd1};

        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; correct_en = 1'b0; out_ready = 1'b0;
        v15 = 1'b0; b15 = 1'b0; ce15 = 1'b0; or15 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        for (int v = 0; v < 13; v++) begin
            send7(vecs[v].word, vecs[v].ce, 0);
            collect7($sformatf("vec%0d", v), 1'b1, 0, d, c);
            check($sformatf("vec%0d data_out", v), d, vecs[v].exp_data);
            check($sformatf("vec%0d err_count", v), c, vecs[v].exp_cnt);
        end

        // correct_en is only sampled with the first bit of a word.
        w = 7'h6D;
        push7(w[6], 1'b0, 0);
        for (int i = 5; i >= 0; i--) push7(w[i], 1'b1, 0);
        collect7("ce0 then 1", 1'b1, 0, d, c);
        check("ce0 then 1 data_out", d, 7'h6D);
        check("ce0 then 1 err_count", c, 3'd1);
        push7(w[6], 1'b1, 0);
        for (int i = 5; i >= 0; i--) push7(w[i], 1'b0, 0);
        collect7("ce1 then 0", 1'b1, 0, d, c);
        check("ce1 then 0 data_out", d, 7'h69);
        check("ce1 then 0 err_count", c, 3'd1);

        // Gapped load, 20-cycle back-pressure, second word queued behind it.
        fork
            begin
                send7(7'h79, 1'b1, 3);
                send7(7'h52, 1'b1, 3);
            end
            begin
                collect7("stressA", 1'b0, 20, d, c);
                check("stressA data_out", d, 7'h69);
                check("stressA err_count", c, 3'd1);
                collect7("stressB", 1'b0, 0, d2, c2);
                check("stressB data_out", d2, 7'h53);
                check("stressB err_count", c2, 3'd1);
            end
        join

        // Reset while loading bit 4.
        push7(1'b1, 1'b1, 0); push7(1'b1, 1'b1, 0); push7(1'b0, 1'b1, 0);
        in_valid = 1'b1; in_bit = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        chk_reset("rst load");

        // Reset in the third decode cycle.
        send7(7'h6D, 1'b1, 0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset("rst decode");

        // Reset while a result is pending.
        send7(7'h6D, 1'b1, 0);
        repeat (10) begin @(posedge clk); #1; end
        check("pending before reset", out_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset("rst done");

        send7(7'h69, 1'b1, 0);
        collect7("post reset", 1'b1, 0, d, c);
        check("post reset data_out", d, 7'h69);
        check("post reset err_count", c, 3'd0);

        // (15,7) BCH: random double errors, corrected and count-only.
        for (int t = 0; t < 10; t++) begin
            cw = encode15(7'($urandom_range(0, 127)));
            p1 = $urandom_range(0, 14);
            p2 = (p1 + int'($urandom_range(1, 14))) % 15;
            rx = cw ^ (15'h0001 << p1) ^ (15'h0001 << p2);
            if (t < 8) run15($sformatf("bch%0d", t), rx, 1'b1, cw, 4'd2);
            else       run15($sformatf("bch%0d", t), rx, 1'b0, rx, 4'd2);
        end
        cw = encode15(7'h5B);
        run15("bch clean", cw, 1'b1, cw, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
